event_encoder_8to3: RTL

Sequential 8-to-3 event encoder: the encoding-side counterpart of the 3-8 decoder. Latches single-cycle event pulses on 8 lines into a pending set and emits one 3-bit index per event, lowest index first, over a valid/ready handshake. Sits between raw event sources (buttons, comparators, interrupt lines) and any consumer that takes one index at a time, such as a 3-8 decoder driving one-hot acknowledges.

---
 rtl/enc_pkg.sv | 12 +
 rtl/lsb_find8.sv | 25 ++
 rtl/event_encoder_8to3.sv | 85 ++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared widths and state encoding for the 8-to-3 event encoder.
package enc_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/lsb_find8.sv
// Combinational lowest-set-bit finder: returns a found flag, the binary index and a one-hot mask.
module lsb_find8
  import enc_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [N_LINES-1:0] mask
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    mask  = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        mask  = N_LINES'(1) << i;
      end
    end
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// Latches event pulses into a pending set and emits one index per event, lowest first,
// over a valid/ready handshake; a second event on a still-pending line sets a sticky overflow.
module event_encoder_8to3
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] ev,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [N_LINES-1:0] pending,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic [N_LINES-1:0] cand;
  logic               cand_found;
  logic [IDX_W-1:0]   cand_idx;
  logic [N_LINES-1:0] cand_mask;
  logic               can_load;
  logic               load;
  logic [N_LINES-1:0] load_mask;
  logic [N_LINES-1:0] collide;

  assign cand = pending_q | ev;

  lsb_find8 u_lsb_find8 (
    .vec   (cand),
    .found (cand_found),
    .idx   (cand_idx),
    .mask  (cand_mask)
  );

  always_comb begin
    can_load  = (state_q == IDLE) || out_ready;
    load      = can_load && cand_found;
    load_mask = load ? cand_mask : '0;

    // A fresh event on the line being loaded this cycle is re-queued rather than lost.
    pending_d = (cand & ~load_mask) | (ev & pending_q & load_mask);
    collide   = ev & pending_q & ~load_mask;

    ovf_d = ovf_q;
    if (|collide) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    state_d = state_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = HOLD;
      idx_d   = cand_idx;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign overflow  = ovf_q;

endmodule
